// File: rtl/vga_fb.sv
// Double-buffered, writable frame buffer for vga_ctrl: pixel replication on the scan
// side, a clear engine and a vblank-synchronised front/back swap on the producer side.
module vga_fb #(
  parameter int unsigned FB_XB  = 8,
  parameter int unsigned FB_YB  = 7,
  parameter int unsigned SHIFT  = 2,
  parameter int unsigned CB     = 4,
  parameter logic [23:0] BORDER = 24'h000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [9:0]          h_addr,
  input  logic [9:0]          v_addr,
  input  logic                de,
  input  logic                vblank,
  output logic [23:0]         vga_data,
  input  logic                wr_en,
  input  logic [FB_XB-1:0]    wr_x,
  input  logic [FB_YB-1:0]    wr_y,
  input  logic [3*CB-1:0]     wr_data,
  output logic                wr_ready,
  input  logic                clear_req,
  input  logic [3*CB-1:0]     clear_color,
  output logic                clear_done,
  input  logic                swap_req,
  output logic                swap_done,
  output logic                front
);

  localparam int unsigned DW    = 3 * CB;
  localparam int unsigned AW    = FB_XB + FB_YB;
  localparam int unsigned DEPTH = 2 ** (AW + 1);
  localparam int unsigned SW    = 10;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CLEAR,
    S_SWAP_WAIT
  } state_t;

  state_t          state;
  logic [DW-1:0]   mem [DEPTH];
  logic [AW-1:0]   clr_addr;
  logic [DW-1:0]   clr_color;
  logic [DW-1:0]   pend_color;
  logic            pend_clear;
  logic            pend_swap;
  logic            vblank_q;

  logic [SW-1:0]   lx_c;
  logic [SW-1:0]   ly_c;
  logic            oob_c;
  logic            swap_fire_c;
  logic            rd_front_c;
  logic [AW:0]     rd_addr_c;
  logic            mem_we_c;
  logic [AW:0]     wr_addr_c;
  logic [DW-1:0]   mem_wd_c;

  // Replicate the top bits of a channel into the low bits to reach 8 bits.
  function automatic logic [7:0] expand(input logic [CB-1:0] n);
    logic [2*CB-1:0] dup;
    dup = {n, n};
    return 8'(dup >> (2 * CB - 8));
  endfunction

  function automatic logic [23:0] expand_pix(input logic [DW-1:0] w);
    return {expand(w[3*CB-1 -: CB]), expand(w[2*CB-1 -: CB]), expand(w[CB-1:0])};
  endfunction

  // Scan address mapping; a swap edge already reads from the new front buffer.
  always_comb begin
    lx_c        = h_addr >> SHIFT;
    ly_c        = v_addr >> SHIFT;
    oob_c       = ((lx_c >> FB_XB) != '0) || ((ly_c >> FB_YB) != '0);
    swap_fire_c = (state == S_SWAP_WAIT) && vblank && !vblank_q;
    rd_front_c  = front ^ swap_fire_c;
    rd_addr_c   = {rd_front_c, ly_c[FB_YB-1:0], lx_c[FB_XB-1:0]};
  end

  // Single write port shared by producers and the clear engine; always targets the back buffer.
  always_comb begin
    mem_we_c  = 1'b0;
    wr_addr_c = {~front, wr_y, wr_x};
    mem_wd_c  = wr_data;
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem_we_c  = 1'b1;
        wr_addr_c = {~front, clr_addr};
        mem_wd_c  = clr_color;
      end else if (wr_en && wr_ready) begin
        mem_we_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we_c) mem[wr_addr_c] <= mem_wd_c;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vga_data <= '0;
    end else if (!de) begin
      vga_data <= '0;
    end else if (oob_c) begin
      vga_data <= BORDER;
    end else begin
      vga_data <= expand_pix(mem[rd_addr_c]);
    end
  end

  // Control FSM: clear beats swap; a request for the busy-with-other operation is held pending.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      front      <= 1'b0;
      wr_ready   <= 1'b1;
      clear_done <= 1'b0;
      swap_done  <= 1'b0;
      pend_clear <= 1'b0;
      pend_swap  <= 1'b0;
      clr_addr   <= '0;
      clr_color  <= '0;
      pend_color <= '0;
      vblank_q   <= 1'b0;
    end else begin
      vblank_q   <= vblank;
      clear_done <= 1'b0;
      swap_done  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (clear_req || pend_clear) begin
            state      <= S_CLEAR;
            clr_color  <= pend_clear ? pend_color : clear_color;
            clr_addr   <= '0;
            pend_clear <= 1'b0;
            wr_ready   <= 1'b0;
            if (swap_req) pend_swap <= 1'b1;
          end else if (swap_req || pend_swap) begin
            state     <= S_SWAP_WAIT;
            pend_swap <= 1'b0;
            wr_ready  <= 1'b0;
          end
        end
        S_CLEAR: begin
          clr_addr <= clr_addr + AW'(1);
          if (swap_req) pend_swap <= 1'b1;
          if (&clr_addr) begin
            state      <= S_IDLE;
            clear_done <= 1'b1;
            wr_ready   <= 1'b1;
          end
        end
        S_SWAP_WAIT: begin
          if (clear_req && !pend_clear) begin
            pend_clear <= 1'b1;
            pend_color <= clear_color;
          end
          if (swap_fire_c) begin
            front     <= ~front;
            swap_done <= 1'b1;
            state     <= S_IDLE;
            wr_ready  <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          wr_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
